fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter OPC_W, default 4, opcode field width (upper field of program byte).
REQ-002 Parameter OPR_W, default 4, operand field width (lower field of program byte).
REQ-003 Parameter PC_W, default 12, program counter width.
REQ-004 Parameter QDEPTH, default 2, prefetch queue entries; legal range 1..8.
REQ-005 clk  in  1  sole clock, all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 prog_addr  out  PC_W  program memory address (equals pc).
REQ-008 prog_req  out  1  fetch issued this cycle.
REQ-009 prog_data  in  OPC_W+OPR_W  memory data, valid exactly one cycle after prog_req.
REQ-010 jump_en  in  1  redirect request this cycle.
REQ-011 jump_addr  in  PC_W  redirect target.
REQ-012 halt  in  1  suspend new fetches.
REQ-013 instr_valid  out  1  queue head valid.
REQ-014 instr_ready  in  1  consumer accepts head.
REQ-015 instruction  out  OPC_W  head[OPC_W+OPR_W-1:OPR_W].
REQ-016 operand  out  OPR_W  head[OPR_W-1:0].

Function
REQ-017 FSM states IDLE, RUN, HALT; IDLE->RUN on first edge with reset low; RUN->HALT when halt=1; HALT->RUN when halt=0.
REQ-018 Issue condition: state RUN, jump_en=0, halt=0, (count + inflight) < QDEPTH; prog_req equals issue condition, combinational.
REQ-019 On issue, pc increments by 1 modulo 2^PC_W (2^PC_W-1 wraps to 0).
REQ-020 inflight register = prog_req of previous cycle; prog_data pushed to queue when inflight=1 and jump_en=0.
REQ-021 Pop when instr_valid=1 and instr_ready=1; simultaneous push and pop leaves count unchanged, order preserved FIFO.
REQ-022 Push into full queue impossible by REQ-018; instr_valid = (count != 0).
REQ-023 instruction/operand driven from head entry; value undefined-but-stable-zero when empty (drive 0).
REQ-024 jump_en=1 (any state except IDLE): pc <= jump_addr, queue cleared, arriving byte discarded, no issue, pop ignored; first fetch from jump_addr next cycle if RUN.
REQ-025 jump_en in HALT: pc and queue updated per REQ-024, state stays HALT.
REQ-026 HALT: queue drains normally through handshake; no issues.
REQ-027 Latency: first edge with reset low = cycle 0 (IDLE); cycle 1 prog_req=1, prog_addr=0; cycle 3 instr_valid=1 holding byte from addr 0.
REQ-028 Steady state with instr_ready=1 and QDEPTH>=2: one instruction per cycle.

Reset
REQ-029 reset=1 forces state IDLE, pc=0, count=0, inflight=0, queue pointers 0.
REQ-030 During reset: prog_req=0, instr_valid=0, instruction=0, operand=0, prog_addr=0.
REQ-031 Reset mid-operation discards queue and any in-flight byte; priority reset > jump_en > halt.

Configuration
REQ-032 Macro FETCH_PHASE_EN defined: adds input port phase (1 bit, after reset); issue additionally requires phase=0 (two-phase Nibbler timing compatibility).
REQ-033 FETCH_PHASE_EN undefined: no phase port; issue per REQ-018 only.

Structure
REQ-034 Package nibbler_fetch_pkg holds fetch_state_e enum (IDLE, RUN, HALT) and default width constants.
REQ-035 Sub-module fetch_fifo (parametrised width, depth; push, pop, flush, count, head) holds queue storage; fetch_stage holds pc, FSM, issue logic.

Verification
REQ-036 Reset, ROM addr n holds byte n, instr_ready=1 -> cycle 1 prog_addr=0; cycle 3 instruction=0, operand=0; cycle 4 operand=1; one per cycle thereafter.
REQ-037 instr_ready=0 from cycle 0, QDEPTH=2 -> exactly 2 issues (addr 0,1), count=2, prog_req stays 0 until a pop.
REQ-038 jump_en=1 with jump_addr=0x0A0 while queue full -> next cycle instr_valid=0, prog_addr=0x0A0, prog_req=1; first instruction/operand from 0x0A0, no stale bytes.
REQ-039 PC_W=4, pc=15, issue -> next prog_addr=0; byte from addr 15 then addr 0 delivered in order.
REQ-040 halt=1 with 2 queued -> both drain, no prog_req; halt=0 -> prog_req resumes at next sequential address.
REQ-041 FETCH_PHASE_EN defined, phase toggling every cycle -> prog_req only in phase=0 cycles; delivered byte sequence identical to REQ-036.

Source files
------------

// File: rtl/nibbler_fetch_pkg.sv
// Shared types and default widths for the Nibbler instruction fetch stage.
package nibbler_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  localparam int DEF_OPC_W  = 4;
  localparam int DEF_OPR_W  = 4;
  localparam int DEF_PC_W   = 12;
  localparam int DEF_QDEPTH = 2;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue for fetched program bytes; flush empties it in one cycle.
module fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [W-1:0]                 din,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [W-1:0]                 head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop)  rd_ptr <= nxt(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_stage.sv
// Nibbler fetch stage: pc, run/halt FSM and fetch issue in front of a prefetch queue.
// Optional FETCH_PHASE_EN adds a 'phase' input; fetches then only issue while phase=0.
//
// state | meaning
// IDLE  | out of reset, no fetch yet
// RUN   | issuing sequential fetches while queue space allows
// HALT  | no new fetches, queue drains through the handshake
module fetch_stage
  import nibbler_fetch_pkg::*;
#(
  parameter int OPC_W  = DEF_OPC_W,
  parameter int OPR_W  = DEF_OPR_W,
  parameter int PC_W   = DEF_PC_W,
  parameter int QDEPTH = DEF_QDEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef FETCH_PHASE_EN
  input  logic                   phase,
`endif
  output logic [PC_W-1:0]        prog_addr,
  output logic                   prog_req,
  input  logic [OPC_W+OPR_W-1:0] prog_data,
  input  logic                   jump_en,
  input  logic [PC_W-1:0]        jump_addr,
  input  logic                   halt,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [OPC_W-1:0]       instruction,
  output logic [OPR_W-1:0]       operand
);

  localparam int W  = OPC_W + OPR_W;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int OW = CW + 1;

  fetch_state_e   state;
  logic [PC_W-1:0] pc;
  logic           inflight;
  logic [CW-1:0]  count;
  logic [W-1:0]   head;
  logic           push;
  logic           pop;
  logic           flush;
  logic           issue;
  logic           phase_ok;
  logic [OW-1:0]  occ;

`ifdef FETCH_PHASE_EN
  assign phase_ok = !phase;
`else
  assign phase_ok = 1'b1;
`endif

  assign instr_valid = !reset && (count != '0);
  assign pop         = instr_valid && instr_ready && !jump_en;
  assign push        = inflight && !jump_en;
  assign flush       = jump_en && (state != IDLE);

  // Slot freed by this cycle's pop counts as space, giving one fetch per cycle in steady state.
  assign occ   = OW'(count) + OW'(inflight) - OW'(pop);
  assign issue = !reset && (state == RUN) && !jump_en && !halt && phase_ok &&
                 (occ < OW'(QDEPTH));

  assign prog_req    = issue;
  assign prog_addr   = reset ? '0 : pc;
  assign instruction = instr_valid ? head[W-1:OPR_W] : '0;
  assign operand     = instr_valid ? head[OPR_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (flush)      pc <= jump_addr;
      else if (issue) pc <= pc + PC_W'(1);
      case (state)
        IDLE:    state <= RUN;
        RUN:     if (halt) state <= HALT;
        HALT:    if (!halt) state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .W     (W),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (prog_data),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: default 12-bit pc instance plus a 4-bit pc instance for wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset4;
  logic [11:0] prog_addr;
  logic        prog_req;
  logic [7:0]  prog_data;
  logic        jump_en;
  logic [11:0] jump_addr;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  instruction;
  logic [3:0]  operand;
`ifdef FETCH_PHASE_EN
  logic        phase;
`endif

  logic [3:0]  p4_addr;
  logic        p4_req;
  logic [7:0]  p4_data;
  logic        i4_valid;
  logic [3:0]  i4_instr;
  logic [3:0]  i4_opnd;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk         (clk),
    .reset       (reset),
`ifdef FETCH_PHASE_EN
    .phase       (phase),
`endif
    .prog_addr   (prog_addr),
    .prog_req    (prog_req),
    .prog_data   (prog_data),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .halt        (halt),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .operand     (operand)
  );

  fetch_stage #(.PC_W(4)) u_dut4 (
    .clk         (clk),
    .reset       (reset4),
`ifdef FETCH_PHASE_EN
    .phase       (1'b0),
`endif
    .prog_addr   (p4_addr),
    .prog_req    (p4_req),
    .prog_data   (p4_data),
    .jump_en     (1'b0),
    .jump_addr   (4'h0),
    .halt        (1'b0),
    .instr_valid (i4_valid),
    .instr_ready (1'b1),
    .instruction (i4_instr),
    .operand     (i4_opnd)
  );

  // ROMs: 12-bit one holds addr[7:0], 4-bit one holds {~addr, addr}; 8'hEE marks an unrequested cycle.
  always @(posedge clk) prog_data <= prog_req ? prog_addr[7:0] : 8'hEE;
  always @(posedge clk) p4_data   <= p4_req ? {~p4_addr, p4_addr} : 8'hEE;

  logic [7:0] q4[$];
  logic [3:0] a4[$];
  always @(negedge clk) begin
    if (!reset4 && i4_valid && q4.size() < 32) q4.push_back({i4_instr, i4_opnd});
    if (!reset4 && p4_req && a4.size() < 32)   a4.push_back(p4_addr);
  end

  typedef struct {
    logic        ready;
    logic        jump;
    logic [11:0] jaddr;
    logic        exp_req;
    logic [11:0] exp_addr;
    logic        exp_valid;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset       = 1'b1;
    jump_en     = 1'b0;
    jump_addr   = '0;
    halt        = 1'b0;
    instr_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_rst_req"},   prog_req, 0);
    chk({tag, "_rst_valid"}, instr_valid, 0);
    chk({tag, "_rst_instr"}, instruction, 0);
    chk({tag, "_rst_opnd"},  operand, 0);
    chk({tag, "_rst_addr"},  prog_addr, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset4 = 1'b1;
`ifdef FETCH_PHASE_EN
    phase = 1'b0;
`endif
    tbl[0]  = '{1'b1, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h000, 1'b0, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h001, 1'b0, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h002, 1'b1, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h003, 1'b1, 8'h01};
    tbl[5]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h004, 1'b1, 8'h02};
    tbl[6]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h005, 1'b1, 8'h03};
    tbl[7]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h006, 1'b1, 8'h04};
    tbl[8]  = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h007, 1'b1, 8'h05};
    tbl[9]  = '{1'b1, 1'b1, 12'h0C5, 1'b0, 12'h008, 1'b1, 8'h06};
    tbl[10] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h0C5, 1'b0, 8'h00};
    tbl[11] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h0C6, 1'b0, 8'h00};
    tbl[12] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h0C7, 1'b1, 8'hC5};
    tbl[13] = '{1'b1, 1'b0, 12'h000, 1'b1, 12'h0C8, 1'b1, 8'hC6};

    // Streaming fetch with a jump while a byte is in flight.
    do_reset("a");
    reset4 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) next_cycle();
      instr_ready = tbl[i].ready;
      jump_en     = tbl[i].jump;
      jump_addr   = tbl[i].jaddr;
      @(negedge clk);
      chk($sformatf("a%0d_req", i),   prog_req, tbl[i].exp_req);
      chk($sformatf("a%0d_addr", i),  prog_addr, tbl[i].exp_addr);
      chk($sformatf("a%0d_valid", i), instr_valid, tbl[i].exp_valid);
      chk($sformatf("a%0d_byte", i),  {instruction, operand}, tbl[i].exp_byte);
    end
    next_cycle();
    jump_en = 1'b0;

    // Mid-operation reset, then consumer stalled: queue fills with exactly two fetches.
    begin
      int n_iss;
      logic [11:0] iss[$];
      do_reset("b");
      n_iss = 0;
      for (int c = 0; c < 9; c++) begin
        if (c > 0) next_cycle();
        @(negedge clk);
        if (prog_req) begin
          n_iss++;
          iss.push_back(prog_addr);
        end
      end
      chk("b_issues", n_iss, 2);
      if (iss.size() == 2) begin
        chk("b_iss0", iss[0], 12'h000);
        chk("b_iss1", iss[1], 12'h001);
      end
      chk("b_full_req",   prog_req, 0);
      chk("b_full_valid", instr_valid, 1);
      chk("b_full_byte",  {instruction, operand}, 8'h00);
    end

    next_cycle();
    instr_ready = 1'b1;
    @(negedge clk);
    chk("b_pop_req",  prog_req, 1);
    chk("b_pop_addr", prog_addr, 12'h002);
    next_cycle();
    instr_ready = 1'b0;
    @(negedge clk);
    chk("b_refill_byte", {instruction, operand}, 8'h01);
    next_cycle();

    // Jump while queue is full.
    next_cycle();
    jump_en   = 1'b1;
    jump_addr = 12'h0A0;
    @(negedge clk);
    chk("c_jump_req", prog_req, 0);
    next_cycle();
    jump_en = 1'b0;
    @(negedge clk);
    chk("c_valid", instr_valid, 0);
    chk("c_addr",  prog_addr, 12'h0A0);
    chk("c_req",   prog_req, 1);
    next_cycle();
    @(negedge clk);
    chk("c_addr2", prog_addr, 12'h0A1);
    next_cycle();
    @(negedge clk);
    chk("c_first_instr", instruction, 4'hA);
    chk("c_first_opnd",  operand, 4'h0);
    next_cycle();

    // Halt with two queued: drain, no fetch, then resume sequentially.
    next_cycle();
    halt        = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk);
    chk("d_h0_req",  prog_req, 0);
    chk("d_h0_byte", {instruction, operand}, 8'hA0);
    next_cycle();
    @(negedge clk);
    chk("d_h1_req",  prog_req, 0);
    chk("d_h1_byte", {instruction, operand}, 8'hA1);
    next_cycle();
    @(negedge clk);
    chk("d_h2_valid", instr_valid, 0);
    chk("d_h2_req",   prog_req, 0);
    next_cycle();
    halt = 1'b0;
    @(negedge clk);
    chk("d_h3_req", prog_req, 0);
    next_cycle();
    @(negedge clk);
    chk("d_r0_req",  prog_req, 1);
    chk("d_r0_addr", prog_addr, 12'h0A2);
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("d_r2_byte", {instruction, operand}, 8'hA2);

`ifdef FETCH_PHASE_EN
    // Phase-gated issue: fetch only on phase=0, delivered stream unchanged.
    begin
      logic [7:0] got[$];
      int n_req;
      do_reset("e");
      instr_ready = 1'b1;
      n_req = 0;
      for (int c = 0; c < 30; c++) begin
        if (c > 0) next_cycle();
        phase = c[0];
        @(negedge clk);
        chk($sformatf("e%0d_phase_req", c), prog_req & phase, 0);
        if (prog_req) n_req++;
        if (instr_valid) got.push_back({instruction, operand});
      end
      phase = 1'b0;
      chk("e_some_req", n_req > 4, 1);
      chk("e_ndeliv", got.size() >= 6, 1);
      for (int k = 0; k < 6 && k < got.size(); k++)
        chk($sformatf("e_byte%0d", k), got[k], k);
    end
`endif

    // 4-bit pc instance: address 15 followed by 0, bytes delivered in order.
    begin
      int budget = 0;
      while ((q4.size() < 18 || a4.size() < 18) && budget < 100) begin
        next_cycle();
        budget++;
      end
      chk("w_enough", (q4.size() >= 18) && (a4.size() >= 18), 1);
      for (int k = 0; k < 18 && k < q4.size() && k < a4.size(); k++) begin
        logic [3:0] a;
        a = 4'(k);
        chk($sformatf("w_addr%0d", k), a4[k], a);
        chk($sformatf("w_byte%0d", k), q4[k], {~a, a});
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
